// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter
//   Registered arbiter between the SERV instruction bus, the SERV data bus and
//   a boot/program loader, all sharing one single-ported SRAM.
//   - The loader has fixed priority over both CPU buses.
//   - ibus and dbus share the SRAM round-robin. On a tie, the bus that did not
//     complete the last transfer wins.
//   - A granted request is latched straight into the SRAM-side output
//     registers. Byte addresses become word addresses.
//   - A GRANT that never sees sram_ack is closed by a forced ack after TIMEOUT
//     cycles, and the sticky o_timeout flag is raised.
//
// Ports
//   clk, i_rst                     clock, synchronous active-high reset
//   i_ibus_*, o_ibus_*             instruction bus (read-only)
//   i_dbus_*, o_dbus_*             data bus (read/write, byte enables)
//   i_ldr_*,  o_ldr_*              loader port (full-word read/write)
//   sram_addr/data_write/we/cs/wmask  registered SRAM request
//   sram_data_read, sram_ack       SRAM response
//   o_timeout                      sticky timeout flag
//
// Parameters
//   TIMEOUT  GRANT cycles without sram_ack before a forced ack (0 = never)
//   CW       width of the GRANT cycle counter; TIMEOUT must be < 2**CW

module soc_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic        clk,
    input  logic        i_rst,
    // instruction bus
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    // data bus
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    // loader
    input  logic [31:0] i_ldr_adr,
    input  logic [31:0] i_ldr_dat,
    input  logic        i_ldr_we,
    input  logic        i_ldr_cyc,
    output logic [31:0] o_ldr_rdt,
    output logic        o_ldr_ack,
    // SRAM
    output logic [31:0] sram_addr,
    input  logic [31:0] sram_data_read,
    output logic [31:0] sram_data_write,
    output logic        sram_we,
    output logic        sram_cs,
    input  logic        sram_ack,
    output logic [3:0]  sram_wmask,
    // status
    output logic        o_timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [1:0] G_IBUS = 2'd0;
    localparam logic [1:0] G_DBUS = 2'd1;
    localparam logic [1:0] G_LDR  = 2'd2;

    localparam bit              TO_EN   = (TIMEOUT != 0);
    localparam int unsigned     TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0]   TO_LAST = CW'(TO_M1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          rr_dbus_last_q, rr_dbus_last_d;   // 1: dbus completed last
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic          sram_cs_q, sram_cs_d;
    logic          sram_we_q, sram_we_d;
    logic [3:0]    sram_wmask_q, sram_wmask_d;
    logic [31:0]   sram_addr_q, sram_addr_d;
    logic [31:0]   sram_wdat_q, sram_wdat_d;

    // ------------------------------------------------------------------
    // GRANT exit conditions
    // ------------------------------------------------------------------
    logic in_grant;
    logic gnt_cyc;
    logic ack_ok;
    logic to_hit;
    logic aborting;
    logic done;

    always_comb begin
        gnt_cyc = 1'b0;
        case (gnt_q)
            G_IBUS:  gnt_cyc = i_ibus_cyc;
            G_DBUS:  gnt_cyc = i_dbus_cyc;
            G_LDR:   gnt_cyc = i_ldr_cyc;
            default: gnt_cyc = 1'b0;
        endcase
    end

    assign in_grant = (state_q == S_GRANT);
    assign ack_ok   = in_grant & sram_ack;
    // A dropped cyc takes precedence over the timeout: an abandoned request
    // gets no ack.
    assign to_hit   = in_grant & TO_EN & ~sram_ack & gnt_cyc & (cnt_q == TO_LAST);
    assign aborting = in_grant & ~sram_ack & ~gnt_cyc;
    assign done     = ack_ok | to_hit;

    // Acks are combinational from sram_ack so data is returned in the ack cycle.
    assign o_ibus_ack = done & (gnt_q == G_IBUS);
    assign o_dbus_ack = done & (gnt_q == G_DBUS);
    assign o_ldr_ack  = done & (gnt_q == G_LDR);

    assign o_ibus_rdt = (to_hit && gnt_q == G_IBUS) ? 32'h0 : sram_data_read;
    assign o_dbus_rdt = (to_hit && gnt_q == G_DBUS) ? 32'h0 : sram_data_read;
    assign o_ldr_rdt  = (to_hit && gnt_q == G_LDR)  ? 32'h0 : sram_data_read;

    // ------------------------------------------------------------------
    // Winner selection (IDLE)
    // ------------------------------------------------------------------
    logic        any_req;
    logic [1:0]  win;
    logic [31:0] win_adr;

    always_comb begin
        any_req = i_ldr_cyc | i_ibus_cyc | i_dbus_cyc;
        win     = G_IBUS;
        if (i_ldr_cyc)
            win = G_LDR;
        else if (i_ibus_cyc && i_dbus_cyc)
            win = rr_dbus_last_q ? G_IBUS : G_DBUS;
        else if (i_dbus_cyc)
            win = G_DBUS;

        win_adr = i_ibus_adr;
        case (win)
            G_DBUS:  win_adr = i_dbus_adr;
            G_LDR:   win_adr = i_ldr_adr;
            default: win_adr = i_ibus_adr;
        endcase
    end

    // Byte-lane bits never reach the word-addressed SRAM.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^win_adr[1:0];

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        rr_dbus_last_d = rr_dbus_last_q;
        cnt_d          = cnt_q;
        timeout_d      = timeout_q;
        sram_cs_d      = sram_cs_q;
        sram_we_d      = sram_we_q;
        sram_wmask_d   = sram_wmask_q;
        sram_addr_d    = sram_addr_q;
        sram_wdat_d    = sram_wdat_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (any_req) begin
                    // The request is latched directly into the SRAM-side
                    // registers, which then stay frozen for the whole GRANT.
                    state_d     = S_GRANT;
                    gnt_d       = win;
                    sram_cs_d   = 1'b1;
                    sram_addr_d = {2'b00, win_adr[31:2]};
                    case (win)
                        G_DBUS: begin
                            sram_wdat_d  = i_dbus_dat;
                            sram_we_d    = i_dbus_we;
                            sram_wmask_d = i_dbus_we ? i_dbus_sel : 4'h0;
                        end
                        G_LDR: begin
                            sram_wdat_d  = i_ldr_dat;
                            sram_we_d    = i_ldr_we;
                            sram_wmask_d = i_ldr_we ? 4'hF : 4'h0;
                        end
                        default: begin
                            sram_wdat_d  = 32'h0;
                            sram_we_d    = 1'b0;
                            sram_wmask_d = 4'h0;
                        end
                    endcase
                end else begin
                    sram_cs_d    = 1'b0;
                    sram_we_d    = 1'b0;
                    sram_wmask_d = 4'h0;
                end
            end

            S_GRANT: begin
                cnt_d = cnt_q + 1'b1;
                if (done || aborting) begin
                    state_d      = S_IDLE;
                    sram_cs_d    = 1'b0;
                    sram_we_d    = 1'b0;
                    sram_wmask_d = 4'h0;
                    sram_addr_d  = 32'h0;
                    sram_wdat_d  = 32'h0;
                    cnt_d        = '0;
                end
                // Only a real SRAM completion moves the round-robin pointer;
                // loader traffic leaves the CPU fairness state alone.
                if (ack_ok && gnt_q != G_LDR)
                    rr_dbus_last_d = (gnt_q == G_DBUS);
                if (to_hit)
                    timeout_d = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            gnt_q          <= G_IBUS;
            rr_dbus_last_q <= 1'b1;     // ibus wins the first tie
            cnt_q          <= '0;
            timeout_q      <= 1'b0;
            sram_cs_q      <= 1'b0;
            sram_we_q      <= 1'b0;
            sram_wmask_q   <= 4'h0;
            sram_addr_q    <= 32'h0;
            sram_wdat_q    <= 32'h0;
        end else begin
            state_q        <= state_d;
            gnt_q          <= gnt_d;
            rr_dbus_last_q <= rr_dbus_last_d;
            cnt_q          <= cnt_d;
            timeout_q      <= timeout_d;
            sram_cs_q      <= sram_cs_d;
            sram_we_q      <= sram_we_d;
            sram_wmask_q   <= sram_wmask_d;
            sram_addr_q    <= sram_addr_d;
            sram_wdat_q    <= sram_wdat_d;
        end
    end

    assign sram_cs         = sram_cs_q;
    assign sram_we         = sram_we_q;
    assign sram_wmask      = sram_wmask_q;
    assign sram_addr       = sram_addr_q;
    assign sram_data_write = sram_wdat_q;
    assign o_timeout       = timeout_q;

endmodule
